// File: rtl/cam_axil_regs_if.sv
// AXI4-Lite channel bundle for the camera capture register file.
interface cam_axil_regs_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cam_axil_regs.sv
// AXI4-Lite register file for the camera capture path: control, frame-buffer
// base address, test-pattern mode, frame counter and sticky interrupt status.
module cam_axil_regs #(
  parameter int          ADDR_W           = 6,
  parameter logic [31:0] RESET_FRAME_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rstn,
  cam_axil_regs_if.slave         axil,
  output logic                   cfg_enable,
  output logic [31:0]            cfg_frame_addr,
  output logic                   cfg_test_mode,
  input  logic                   sts_busy,
  input  logic                   frame_done,
  input  logic                   fifo_ovf,
  output logic                   irq
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] OFS_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] OFS_FADDR  = IDX_W'(1);
  localparam logic [IDX_W-1:0] OFS_STATUS = IDX_W'(2);
  localparam logic [IDX_W-1:0] OFS_TEST   = IDX_W'(3);
  localparam logic [IDX_W-1:0] OFS_IRQ    = IDX_W'(4);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_t;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_t;

  // Byte-lane merge of a write into an existing 32-bit register.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // The decoded map is contiguous from offset 0 up to IRQ_STAT.
  function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
    return idx <= OFS_IRQ;
  endfunction

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              active;
  logic              aw_held, w_held;
  logic              aw_hs, w_hs, ar_hs, do_write;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       wr_data, rd_word;
  logic [3:0]        wr_strb;
  logic [1:0]        stat_clr;
  logic [2:0]        ctrl_q;
  logic [31:0]       frame_addr_q;
  logic              test_q;
  logic [1:0]        stat_q;
  logic [15:0]       frame_cnt_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{axil.awaddr[1:0], axil.araddr[1:0]};

  // A channel that has not yet handshaken supplies its beat directly, so the
  // write lands on the same edge as the later of the AW/W handshakes.
  assign wr_idx  = aw_held ? aw_idx_q : axil.awaddr[ADDR_W-1:2];
  assign wr_data = w_held  ? wdata_q  : axil.wdata;
  assign wr_strb = w_held  ? wstrb_q  : axil.wstrb;
  assign rd_idx  = axil.araddr[ADDR_W-1:2];

  // Write FSM next-state, ready/valid outputs and write-apply strobe.
  always_comb begin
    w_next       = w_state;
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    axil.bvalid  = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    do_write     = 1'b0;
    case (w_state)
      W_IDLE: begin
        axil.awready = active & ~aw_held;
        axil.wready  = active & ~w_held;
        aw_hs        = axil.awvalid & active & ~aw_held;
        w_hs         = axil.wvalid & active & ~w_held;
        if ((aw_held | aw_hs) && (w_held | w_hs)) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP: begin
        axil.bvalid = 1'b1;
        if (axil.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM state, AW/W capture flags and response code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state    <= W_IDLE;
      active     <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      axil.bresp <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      active  <= 1'b1;
      if (do_write) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        axil.bresp <= is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end
  end

  // Holding registers for an early AW or W beat; qualified by the held flags.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx_q <= axil.awaddr[ADDR_W-1:2];
    if (w_hs) begin
      wdata_q <= axil.wdata;
      wstrb_q <= axil.wstrb;
    end
  end

  assign stat_clr = (do_write && wr_idx == OFS_IRQ && wr_strb[0]) ? wr_data[1:0] : 2'b00;

  // Configuration registers, frame counter, sticky status and interrupt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q       <= '0;
      frame_addr_q <= RESET_FRAME_ADDR;
      test_q       <= 1'b0;
      stat_q       <= '0;
      frame_cnt_q  <= '0;
      irq          <= 1'b0;
    end else begin
      if (do_write && wr_idx == OFS_CTRL && wr_strb[0]) ctrl_q <= wr_data[2:0];
      if (do_write && wr_idx == OFS_FADDR) frame_addr_q <= merge_strb(frame_addr_q, wr_data, wr_strb);
      if (do_write && wr_idx == OFS_TEST && wr_strb[0]) test_q <= wr_data[0];
      stat_q <= (stat_q & ~stat_clr) | {fifo_ovf, frame_done};
      if (frame_done && ctrl_q[0]) frame_cnt_q <= frame_cnt_q + 16'd1;
      irq <= (stat_q[0] & ctrl_q[1]) | (stat_q[1] & ctrl_q[2]);
    end
  end

  // Read data mux; busy is captured live at the AR handshake.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      OFS_CTRL:   rd_word = {29'b0, ctrl_q};
      OFS_FADDR:  rd_word = frame_addr_q;
      OFS_STATUS: rd_word = {frame_cnt_q, 15'b0, sts_busy};
      OFS_TEST:   rd_word = {31'b0, test_q};
      OFS_IRQ:    rd_word = {30'b0, stat_q};
      default:    rd_word = '0;
    endcase
  end

  // Read FSM next-state and ready/valid outputs.
  always_comb begin
    r_next       = r_state;
    axil.arready = 1'b0;
    axil.rvalid  = 1'b0;
    ar_hs        = 1'b0;
    case (r_state)
      R_IDLE: begin
        axil.arready = active;
        ar_hs        = axil.arvalid & active;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: begin
        axil.rvalid = 1'b1;
        if (axil.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM state and latched read data/response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= R_IDLE;
      axil.rdata <= '0;
      axil.rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        axil.rdata <= rd_word;
        axil.rresp <= is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign cfg_enable     = ctrl_q[0];
  assign cfg_frame_addr = frame_addr_q;
  assign cfg_test_mode  = test_q;

endmodule

// File: tb/tb_cam_axil_regs.sv
// Self-checking bench for cam_axil_regs: directed scenarios followed by a
// randomized mix of reads, writes and status pulses against a register model.
module tb_cam_axil_regs;

  localparam logic [31:0] RST_FA = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_enable, cfg_test_mode, irq;
  logic [31:0] cfg_frame_addr;
  logic        sts_busy, frame_done, fifo_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register state
  logic [2:0]  m_ctrl;
  logic [31:0] m_faddr;
  logic        m_test;
  logic [1:0]  m_stat;
  logic [15:0] m_cnt;

  cam_axil_regs_if #(.ADDR_W(6)) bus ();

  cam_axil_regs #(.ADDR_W(6), .RESET_FRAME_ADDR(RST_FA)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .axil           (bus),
    .cfg_enable     (cfg_enable),
    .cfg_frame_addr (cfg_frame_addr),
    .cfg_test_mode  (cfg_test_mode),
    .sts_busy       (sts_busy),
    .frame_done     (frame_done),
    .fifo_ovf       (fifo_ovf),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_faddr = RST_FA; m_test = 1'b0; m_stat = '0; m_cnt = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a, input logic busy);
    case (a[5:2])
      4'd0: return {29'b0, m_ctrl};
      4'd1: return m_faddr;
      4'd2: return {m_cnt, 15'b0, busy};
      4'd3: return {31'b0, m_test};
      4'd4: return {30'b0, m_stat};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input logic [5:0] a);
    return (a[5:2] <= 4'd4) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic model_irq();
    return (m_stat[0] & m_ctrl[1]) | (m_stat[1] & m_ctrl[2]);
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[5:2])
      4'd0: if (s[0]) m_ctrl = d[2:0];
      4'd1: for (int b = 0; b < 4; b++) if (s[b]) m_faddr[8*b +: 8] = d[8*b +: 8];
      4'd3: if (s[0]) m_test = d[0];
      4'd4: if (s[0]) m_stat = m_stat & ~d[1:0];
      default: ;
    endcase
  endtask

  task automatic model_pulse(input logic fd, input logic ov);
    if (fd) begin
      if (m_ctrl[0]) m_cnt = m_cnt + 16'd1;
      m_stat[0] = 1'b1;
    end
    if (ov) m_stat[1] = 1'b1;
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_enable"}, cfg_enable, m_ctrl[0]);
    check({tag, "_faddr"},  cfg_frame_addr, m_faddr);
    check({tag, "_test"},   cfg_test_mode, m_test);
    check({tag, "_irq"},    irq, model_irq());
  endtask

  // Full write transaction; AW and W each start after their own cycle delay.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      if (w_done && !aw_done && !bus.awvalid) begin
        check("awready_while_waiting", bus.awready, 1'b1);
        check("wready_after_w_held", bus.wready, 1'b0);
      end
      @(posedge clk); #1;
      aw_done = aw_done | aw_now;
      w_done  = w_done | w_now;
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    check("bvalid_latency", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(posedge clk); #1;
    check("bvalid_release", bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done;
    int cyc;
    done = 0; cyc = 0; d = '0; resp = 2'b11;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      done = bus.arready;
      @(posedge clk); #1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    if (!done) begin
      check("read_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    check("rvalid_latency", bus.rvalid, 1'b1);
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    check("rvalid_release", bus.rvalid, 1'b0);
  endtask

  task automatic pulse(input logic fd, input logic ov);
    frame_done = fd; fifo_ovf = ov;
    @(posedge clk); #1;
    frame_done = 1'b0; fifo_ovf = 1'b0;
    model_pulse(fd, ov);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.awready, 1'b0);
    check({tag, "_wready"},  bus.wready, 1'b0);
    check({tag, "_arready"}, bus.arready, 1'b0);
    check({tag, "_bvalid"},  bus.bvalid, 1'b0);
    check({tag, "_rvalid"},  bus.rvalid, 1'b0);
    check({tag, "_bresp"},   bus.bresp, 2'b00);
    check({tag, "_rresp"},   bus.rresp, 2'b00);
    check({tag, "_rdata"},   bus.rdata, 32'h0);
    check({tag, "_irq"},     irq, 1'b0);
    check({tag, "_enable"},  cfg_enable, 1'b0);
    check({tag, "_faddr"},   cfg_frame_addr, RST_FA);
    check({tag, "_test"},    cfg_test_mode, 1'b0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    rstn = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    sts_busy = 1'b0; frame_done = 1'b0; fifo_ovf = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // AW and W together
    axi_write(6'h04, 32'h44A0_0000, 4'hF, 0, 0, resp);
    model_write(6'h04, 32'h44A0_0000, 4'hF);
    check("faddr_bresp", resp, 2'b00);
    check("faddr_cfg", cfg_frame_addr, 32'h44A0_0000);
    axi_read(6'h04, rd, resp);
    check("faddr_rdata", rd, 32'h44A0_0000);
    check("faddr_rresp", resp, 2'b00);

    // W three cycles ahead of AW
    axi_write(6'h00, 32'h1, 4'hF, 3, 0, resp);
    model_write(6'h00, 32'h1, 4'hF);
    check("ctrl_bresp", resp, 2'b00);
    check("ctrl_enable", cfg_enable, 1'b1);
    axi_write(6'h0C, 32'h1, 4'hF, 0, 0, resp);
    model_write(6'h0C, 32'h1, 4'hF);
    check("test_mode", cfg_test_mode, 1'b1);

    // Partial strobe
    axi_write(6'h04, 32'hDEAD_BEEF, 4'b0011, 0, 1, resp);
    model_write(6'h04, 32'hDEAD_BEEF, 4'b0011);
    axi_read(6'h04, rd, resp);
    check("partial_strobe", rd, 32'h44A0_BEEF);

    // Frame counting gated by enable
    repeat (3) pulse(1'b1, 1'b0);
    axi_write(6'h00, 32'h0, 4'hF, 0, 0, resp);
    model_write(6'h00, 32'h0, 4'hF);
    repeat (2) pulse(1'b1, 1'b0);
    axi_write(6'h00, 32'h3, 4'hF, 0, 0, resp);
    model_write(6'h00, 32'h3, 4'hF);
    axi_read(6'h08, rd, resp);
    check("status_cnt3", rd, 32'h0003_0000);
    check("irq_frame_set", irq, 1'b1);
    axi_write(6'h10, 32'h1, 4'hF, 0, 0, resp);
    model_write(6'h10, 32'h1, 4'hF);
    check("irq_after_w1c", irq, 1'b0);

    // frame_done in the same cycle as the W1C apply: set wins
    bus.awaddr = 6'h10; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; frame_done = 1'b1;
    @(negedge clk);
    check("same_cycle_ready", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; frame_done = 1'b0;
    model_write(6'h10, 32'h1, 4'hF);
    model_pulse(1'b1, 1'b0);
    check("same_cycle_bvalid", bus.bvalid, 1'b1);
    @(posedge clk); #1;
    check("same_cycle_irq", irq, 1'b1);
    axi_read(6'h10, rd, resp);
    check("same_cycle_stat", rd, 32'h1);
    axi_read(6'h08, rd, resp);
    check("status_cnt4", rd, model_read(6'h08, 1'b0));

    // Unmapped offsets
    axi_read(6'h14, rd, resp);
    check("unmapped_rresp", resp, 2'b10);
    check("unmapped_rdata", rd, 32'h0);
    axi_write(6'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    check("unmapped_bresp", resp, 2'b10);
    check_cfg("unmapped_nochange");
    axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    check("status_write_bresp", resp, 2'b00);
    axi_read(6'h08, rd, resp);
    check("status_write_noeffect", rd, model_read(6'h08, 1'b0));

    // Backpressure on both response channels
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 6'h0C; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 6'h04; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    model_write(6'h0C, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", bus.bvalid, 1'b1);
      check("bp_rvalid", bus.rvalid, 1'b1);
      check("bp_rdata", bus.rdata, m_faddr);
      check("bp_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    check("bp_release_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check_cfg("bp_cfg");

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 6'($urandom_range(0, 7) * 4);
          d = $urandom;
          s = 4'($urandom_range(0, 15));
          axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
          check("rand_bresp", resp, model_resp(a));
          model_write(a, d, s);
          check_cfg("rand_wr");
        end
        1: begin
          pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          check("rand_pulse_irq", irq, model_irq());
        end
        default: begin
          a = 6'($urandom_range(0, 7) * 4);
          sts_busy = 1'($urandom_range(0, 1));
          axi_read(a, rd, resp);
          check("rand_rdata", rd, model_read(a, sts_busy));
          check("rand_rresp", resp, model_resp(a));
        end
      endcase
    end
    sts_busy = 1'b0;

    // Reset while a W beat is held
    bus.awaddr = 6'h04; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.awaddr = 6'h0C; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midreset_no_stale_w", bus.bvalid, 1'b0);
      @(posedge clk); #1;
    end
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    check("midreset_late_w_bvalid", bus.bvalid, 1'b1);
    @(posedge clk); #1;
    model_write(6'h0C, 32'h1, 4'hF);
    check_cfg("midreset_cfg");
    axi_read(6'h04, rd, resp);
    check("midreset_faddr", rd, RST_FA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
